// File: rtl/seq_det_ctrl.sv
// Serial pattern detector with IDLE/RUN/DONE control, a configurable pattern, length and match target.
// Define SEQ_DET_OVERLAP_EN to let matches overlap; by default each match needs len fresh bits.
module seq_det_ctrl #(
   parameter int MAX_LEN = 8,
   parameter int CNT_W   = 8
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               cfg_we,
   input  logic [MAX_LEN-1:0] cfg_pat,
   input  logic [3:0]         cfg_len,
   input  logic [CNT_W-1:0]   cfg_target,
   input  logic               start,
   input  logic               stop,
   input  logic               a,
   input  logic               a_valid,
   output logic               y,
   output logic               busy,
   output logic               done,
   output logic [CNT_W-1:0]   match_cnt
);

   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_RUN  = 2'd1;
   localparam logic [1:0] S_DONE = 2'd2;

   localparam logic [3:0]         LEN_MAX = 4'(MAX_LEN);
   localparam logic [3:0]         LEN_RST = (MAX_LEN < 3) ? 4'(MAX_LEN) : 4'd3;
   localparam logic [MAX_LEN-1:0] PAT_RST = MAX_LEN'(3'b101);
   localparam logic [CNT_W-1:0]   CNT_MAX = '1;

   function automatic logic [3:0] clamp_len(input logic [3:0] l);
      if (l == 4'd0)
         return 4'd1;
      else if (l > LEN_MAX)
         return LEN_MAX;
      else
         return l;
   endfunction

   function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
      return (c == CNT_MAX) ? c : c + CNT_W'(1);
   endfunction

   logic [1:0]         state_q, state_d;
   logic [MAX_LEN-1:0] pat_q, pat_d;
   logic [3:0]         len_q, len_d;
   logic [CNT_W-1:0]   tgt_q, tgt_d;
   logic [MAX_LEN-1:0] hist_q, hist_d;
   logic [3:0]         fill_q, fill_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;
   logic               y_q, y_d;

   logic [MAX_LEN-1:0] len_mask;
   logic [MAX_LEN-1:0] hist_sh;
   logic [3:0]         fill_inc;
   logic [CNT_W-1:0]   cnt_inc;
   logic               sample;
   logic               hit;

   always_comb begin
      len_mask = '0;
      for (int i = 0; i < MAX_LEN; i++)
         len_mask[i] = (4'(i) < len_q);
   end

   // start and stop take priority over sampling in the same cycle
   assign sample   = (state_q == S_RUN) && a_valid && !start && !stop;
   assign hist_sh  = (hist_q << 1) | MAX_LEN'(a);
   assign fill_inc = (fill_q >= LEN_MAX) ? LEN_MAX : fill_q + 4'd1;
   assign hit      = sample && (fill_inc >= len_q) &&
                     (((hist_sh ^ pat_q) & len_mask) == '0);
   assign cnt_inc  = sat_inc(cnt_q);

   always_comb begin
      state_d = state_q;
      pat_d   = pat_q;
      len_d   = len_q;
      tgt_d   = tgt_q;
      hist_d  = hist_q;
      fill_d  = fill_q;
      cnt_d   = cnt_q;
      y_d     = 1'b0;

      if (cfg_we && (state_q != S_RUN)) begin
         pat_d = cfg_pat;
         len_d = clamp_len(cfg_len);
         tgt_d = cfg_target;
      end

      if (start) begin
         state_d = S_RUN;
         hist_d  = '0;
         fill_d  = '0;
         cnt_d   = '0;
      end else if (stop) begin
         state_d = S_IDLE;
      end else if (sample) begin
         hist_d = hist_sh;
         fill_d = fill_inc;
         if (hit) begin
            y_d   = 1'b1;
            cnt_d = cnt_inc;
`ifdef SEQ_DET_OVERLAP_EN
            fill_d = fill_inc;
`else
            fill_d = '0;
`endif
            if ((tgt_q != '0) && (cnt_inc == tgt_q))
               state_d = S_DONE;
         end
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q <= S_IDLE;
         pat_q   <= PAT_RST;
         len_q   <= LEN_RST;
         tgt_q   <= '0;
         hist_q  <= '0;
         fill_q  <= '0;
         cnt_q   <= '0;
         y_q     <= 1'b0;
      end else begin
         state_q <= state_d;
         pat_q   <= pat_d;
         len_q   <= len_d;
         tgt_q   <= tgt_d;
         hist_q  <= hist_d;
         fill_q  <= fill_d;
         cnt_q   <= cnt_d;
         y_q     <= y_d;
      end
   end

   assign y         = y_q;
   assign busy      = (state_q == S_RUN);
   assign done      = (state_q == S_DONE);
   assign match_cnt = cnt_q;

endmodule

// File: tb/tb_seq_det_ctrl.sv
// Directed bench for seq_det_ctrl: expected y per cycle is queued at drive time and popped at the sample point.
module tb_seq_det_ctrl;

   localparam int MAX_LEN = 8;
   localparam int CNT_W   = 8;

   logic               clk = 1'b0;
   logic               rst;
   logic               cfg_we;
   logic [MAX_LEN-1:0] cfg_pat;
   logic [3:0]         cfg_len;
   logic [CNT_W-1:0]   cfg_target;
   logic               start;
   logic               stop;
   logic               a;
   logic               a_valid;
   logic               y;
   logic               busy;
   logic               done;
   logic [CNT_W-1:0]   match_cnt;

   int   n_tests = 0;
   int   n_fail  = 0;
   logic exp_q[$];

   always #5 clk = ~clk;

   seq_det_ctrl #(.MAX_LEN(MAX_LEN), .CNT_W(CNT_W)) dut (
      .clk(clk), .rst(rst), .cfg_we(cfg_we), .cfg_pat(cfg_pat), .cfg_len(cfg_len),
      .cfg_target(cfg_target), .start(start), .stop(stop), .a(a), .a_valid(a_valid),
      .y(y), .busy(busy), .done(done), .match_cnt(match_cnt)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
      n_tests++;
      assert (obs === exp_v) else begin
         n_fail++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp_v);
      end
   endtask

   task automatic chk_y();
      logic e;
      if (exp_q.size() == 0) begin
         n_tests++;
         n_fail++;
         $error("FAIL y_queue: observed empty expected an entry");
      end else begin
         e = exp_q.pop_front();
         n_tests++;
         assert (y === e) else begin
            n_fail++;
            $error("FAIL y: observed %b expected %b at %0t", y, e, $time);
         end
      end
   endtask

   // Called at a falling edge: drive, let one rising edge pass, compare y at the next falling edge.
   task automatic step(input logic st, input logic sp, input logic we,
                       input logic av, input logic ab, input logic ey);
      start = st; stop = sp; cfg_we = we; a_valid = av; a = ab;
      exp_q.push_back(ey);
      @(negedge clk);
      chk_y();
      start = 1'b0; stop = 1'b0; cfg_we = 1'b0; a_valid = 1'b0;
   endtask

   task automatic stream(input logic [15:0] bits, input logic [15:0] ys, input int n);
      for (int i = n - 1; i >= 0; i--)
         step(1'b0, 1'b0, 1'b0, 1'b1, bits[i], ys[i]);
   endtask

   task automatic idle(input int k);
      for (int i = 0; i < k; i++)
         step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
   endtask

   task automatic do_cfg(input logic [MAX_LEN-1:0] p, input logic [3:0] l, input logic [CNT_W-1:0] t);
      cfg_pat = p; cfg_len = l; cfg_target = t;
      step(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
   endtask

   initial begin
      rst = 1'b0; start = 1'b0; stop = 1'b0; cfg_we = 1'b0; a = 1'b0; a_valid = 1'b0;
      cfg_pat = '0; cfg_len = '0; cfg_target = '0;

      @(negedge clk);
      chk("rst_y", y, 0);
      chk("rst_busy", busy, 0);
      chk("rst_done", done, 0);
      chk("rst_cnt", match_cnt, 0);
      rst = 1'b1;

      // Reset defaults: pattern 101, len 3, unlimited target
      step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      chk("t1_busy", busy, 1);
      chk("t1_cnt0", match_cnt, 0);
`ifdef SEQ_DET_OVERLAP_EN
      stream(16'b10101, 16'b00101, 5);
      chk("t1_cnt", match_cnt, 2);
`else
      stream(16'b10101, 16'b00100, 5);
      chk("t1_cnt", match_cnt, 1);
`endif
      idle(1);
      chk("t1_busy_hold", busy, 1);
      chk("t1_done", done, 0);

      // Pattern 1101, target 2 ends the run
      step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
      chk("t2_stop_busy", busy, 0);
      chk("t2_stop_done", done, 0);
      do_cfg(8'b0000_1101, 4'd4, 8'd2);
      step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
`ifdef SEQ_DET_OVERLAP_EN
      stream(16'b1101101, 16'b0001001, 7);
`else
      stream(16'b11011101, 16'b00010001, 8);
`endif
      chk("t2_done", done, 1);
      chk("t2_busy", busy, 0);
      chk("t2_cnt", match_cnt, 2);
      stream(16'b1101, 16'b0000, 4);
      chk("t2_cnt_hold", match_cnt, 2);
      chk("t2_done_hold", done, 1);

      // Reconfigure in DONE, gap in a_valid, cfg ignored in RUN
      do_cfg(8'b0000_0101, 4'd3, 8'd0);
      step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      chk("t3_cnt_clr", match_cnt, 0);
      stream(16'b10, 16'b00, 2);
      idle(3);
      stream(16'b1, 16'b1, 1);
      chk("t3_cnt", match_cnt, 1);
      do_cfg(8'h00, 4'd1, 8'd1);
      stream(16'b101, 16'b001, 3);
      chk("t3_cfg_ignored_cnt", match_cnt, 2);
      chk("t3_cfg_ignored_busy", busy, 1);

      // Asynchronous reset mid-run
      stream(16'b10, 16'b00, 2);
      #2 rst = 1'b0;
      #1;
      chk("t4_rst_y", y, 0);
      chk("t4_rst_busy", busy, 0);
      chk("t4_rst_done", done, 0);
      chk("t4_rst_cnt", match_cnt, 0);
      @(negedge clk);
      rst = 1'b1;
      step(1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
      chk("t4_idle_busy", busy, 0);
      chk("t4_idle_cnt", match_cnt, 0);
      step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      stream(16'b101, 16'b001, 3);
      chk("t4_default_cnt", match_cnt, 1);

      // Length 0 clamps to 1, target 1
      step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
      do_cfg(8'h01, 4'd0, 8'd1);
      step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      stream(16'b01, 16'b01, 2);
      chk("t5_done", done, 1);
      chk("t5_busy", busy, 0);
      chk("t5_cnt", match_cnt, 1);
      step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
      chk("t5_stop_done", done, 0);
      chk("t5_stop_cnt", match_cnt, 1);

      // Length above MAX_LEN clamps to MAX_LEN
      do_cfg(8'hFF, 4'd15, 8'd0);
      step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      stream(16'h00FF, 16'h0001, 8);
      chk("t6_cnt", match_cnt, 1);

      // Match counter saturates
      step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
      do_cfg(8'h01, 4'd1, 8'd0);
      step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      for (int i = 0; i < 260; i++)
         step(1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1);
      chk("t7_sat_cnt", match_cnt, 255);
      chk("t7_busy", busy, 1);

      chk("queue_empty", exp_q.size(), 0);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/seq_det_ctrl.md
SEQ_DET_CTRL -- requirements
Module: seq_det_ctrl

Interface
REQ-001 Parameter MAX_LEN, 8, maximum pattern length in bits (2..15).
REQ-002 Parameter CNT_W, 8, width of match counter and target.
REQ-003 One clock; reset is asynchronous and active-low.
REQ-004 clk  input  1  rising-edge clock.
REQ-005 rst  input  1  asynchronous active-low reset.
REQ-006 cfg_we  input  1  load cfg_pat, cfg_len and cfg_target.
REQ-007 cfg_pat  input  MAX_LEN  pattern; bit 0 = last bit received.
REQ-008 cfg_len  input  4  pattern length in bits.
REQ-009 cfg_target  input  CNT_W  match count ending the run; 0 = unlimited.
REQ-010 start  input  1  clear history and counter, enter RUN.
REQ-011 stop  input  1  abort run, return to IDLE.
REQ-012 a  input  1  serial data bit.
REQ-013 a_valid  input  1  a is valid this cycle.
REQ-014 y  output  1  one-cycle match pulse.
REQ-015 busy  output  1  high in RUN.
REQ-016 done  output  1  high in DONE.
REQ-017 match_cnt  output  CNT_W  matches in current or last run.

Function
REQ-018 States IDLE, RUN and DONE shall be used; IDLE->RUN on start; RUN->IDLE on stop; RUN->DONE at the edge where match_cnt reaches a nonzero target; DONE->RUN on start; DONE->IDLE on stop.
REQ-019 cfg_we shall be honoured in IDLE and DONE only; in RUN it shall be ignored.
REQ-020 Stored length 0 shall be clamped to 1 and values above MAX_LEN to MAX_LEN at load.
REQ-021 start in any state shall clear history, fill count and match_cnt, and enter RUN; start shall win over simultaneous stop.
REQ-022 In RUN with a_valid=1, each edge shall shift a into history LSB and increment the fill count, saturating at MAX_LEN; a_valid=0 shall hold both.
REQ-023 A match shall occur at an edge where fill count after the shift is at least len and the low len history bits equal the low len pattern bits.
REQ-024 On a match, y shall be high for exactly the cycle after the sampling edge (registered, latency 1) and match_cnt shall increment at that edge, saturating at all-ones.
REQ-025 No sampling, matching or y pulse shall occur in IDLE or DONE; match_cnt shall hold its value there.
REQ-026 A match at the edge where RUN->DONE occurs shall still pulse y and count.

Reset
REQ-027 Asserting rst low shall immediately force IDLE, y=0, busy=0, done=0, match_cnt=0, history=0 and fill=0.
REQ-028 Reset shall also load pattern 3'b101, len 3 and target 0.
REQ-029 Reset mid-run shall discard partial history, with no y pulse on release.

Configuration
REQ-030 SEQ_DET_OVERLAP_EN defined: matches may overlap, and history and fill are kept after a match.
REQ-031 SEQ_DET_OVERLAP_EN undefined: the fill count shall clear to 0 at each match edge, so a new match needs len fresh bits.

Verification
REQ-032 Reset defaults, start, a=1,0,1,0,1 every cycle, overlap enabled -> y pulses after bits 3 and 5, match_cnt=2.
REQ-033 Same stimulus with the macro undefined -> single y pulse after bit 3, match_cnt=1.
REQ-034 cfg pattern 4'b1101, len 4, target 2; start; a=1,1,0,1,1,0,1 -> matches after bits 4 and 7, done=1 and busy=0 from that edge, later bits ignored.
REQ-035 Start and stream 1,0 with a_valid, then a_valid=0 for 3 cycles, then a=1 -> one y pulse, no pulse during gap.
REQ-036 Assert rst low mid-run after bits 1,0 -> all outputs 0 asynchronously; after release a=1 gives no y.
REQ-037 cfg_len=0 then pattern bit 0=1 and target 1; start; a=0,1 -> y after the second bit, done=1.
